i2s_transmitter: RTL and testbench
==================================

Name: i2s_transmitter

Overview:
- I2S master transmitter for the NCO audio path.
- Runs from a 24.576 MHz master clock and generates the bit clock (BCLK), word select (WS) and serial data (SD) for a 48 kHz, 2×16-bit frame.
- Each 16-bit signed sample from the NCO is sent MSB-first on both left and right channels (mono duplicated).
- Also drives a debug bit-position output and a heartbeat LED.

Parameters:
- CLK_DIV, 16, master clocks per BCLK period; must be even and ≥4 (24.576 MHz / 16 = 1.536 MHz = 48 kHz × 32).
- LED_TOGGLE_FRAMES, 24000, frames between heartbeat LED toggles (1 Hz blink at 48 kHz).

Ports:
- clk  in  1  master clock, 24.576 MHz, all logic on rising edge.
- rst  in  1  synchronous, active-low reset.
- new_sound_sample  in  16  PCM sample, two's complement; sampled once per frame.
- bit_clk_enable  out  1  one-clk strobe marking each BCLK falling edge (bit-slot boundary).
- bit_clock  out  1  I2S BCLK, 50% duty.
- word_select  out  1  I2S WS/LRCLK; 0 = left, 1 = right.
- sound_data  out  1  I2S SD.
- test_LED_B  out  1  heartbeat LED.
- testing_bit_counter  out  5  current bit slot in frame, 0..31.

Behaviour:
- Reset (rst==0 at a clk edge): div_cnt=0, bit counter=0, held sample=0, bit_clock=0, word_select=0, sound_data=0, bit_clk_enable=0, test_LED_B=0, frame counter=0.
- Reset has priority over all other activity, including mid-frame; the frame restarts from slot 0.
- Divider: div_cnt counts 0..CLK_DIV-1 and wraps to 0.
- bit_clock (registered) is 0 while div_cnt < CLK_DIV/2 and 1 otherwise.
- bit_clk_enable (registered) is 1 for exactly one clk, during the cycle where div_cnt == CLK_DIV-1. The first strobe occurs CLK_DIV cycles after reset release.
- On each clk edge where bit_clk_enable==1, which coincides with the BCLK falling edge:
  - slot b ← b+1 mod 32; 31 wraps to 0.
  - On the 31→0 wrap, latch new_sound_sample into the held register; frame counter += 1.
  - word_select ← 1 if the new b is in 15..30, else 0. WS therefore leads each channel's MSB by one BCLK, per I2S.
  - sound_data ← held[15 − (new b mod 16)], using the freshly latched sample when new b = 0. Slots 0..15 carry the left channel and 16..31 the right, each MSB-first.
- All outputs change only at BCLK falling edges (except bit_clock itself), so they are stable at BCLK rising edges for the receiver.
- Sample latency: a sample present at the 31→0 wrap has its MSB on sound_data from that edge. Frames before the first latch transmit zeros.
- new_sound_sample may change at any time; only its value at the wrap edge matters.
- Heartbeat: when the frame counter reaches LED_TOGGLE_FRAMES, toggle test_LED_B and clear the counter.
- testing_bit_counter mirrors slot b.

Optional Feature:
- Macro I2S_DEBUG_EN.
- Defined: testing_bit_counter outputs slot b; test_LED_B is the heartbeat described above.
- Undefined: testing_bit_counter is tied to 5'd0, test_LED_B is tied to 0, and the heartbeat counter logic is removed.
- I2S outputs are identical in both builds.

Test Plan:
- Reset: hold rst=0 for 2 clks, then release → all outputs 0; first bit_clk_enable pulse on the 16th clk after release; bit_clock period 16 clks, high for 8.
- Slot sequence: sample each bit_clk_enable for 32 strobes (I2S_DEBUG_EN) → testing_bit_counter goes 0,1,…,31 then wraps to 0; word_select=1 only for slots 15..30.
- Data: new_sound_sample=16'hA5C3 held constant → second frame shows sound_data slots 0..15 = 1010010111000011, and the same in slots 16..31; the first frame after reset is all zeros.
- Sample change mid-frame: change the input to 16'h7FFF at slot 10 → current frame unchanged; next frame = 0111111111111111 on both channels.
- Reset mid-frame: drive rst=0 at slot 20 → next clk: slot 0, WS=0, SD=0, div_cnt restarts.
- Heartbeat: set LED_TOGGLE_FRAMES=2 → test_LED_B toggles every 2 frame wraps (every 1024 clks).

Source files
------------

// File: rtl/i2s_transmitter.sv
// -----------------------------------------------------------------------------
// i2s_transmitter
//
// I2S master transmitter for the NCO audio path. From the master clock it
// derives BCLK (CLK_DIV master clocks per bit), WS and SD for a 2 x 16-bit
// frame. Each sample is sent MSB-first on both channels (mono duplicated).
//
// Optional build macro: I2S_DEBUG_EN
//   defined   -> testing_bit_counter shows the current bit slot and
//                test_LED_B blinks once every LED_TOGGLE_FRAMES frames.
//   undefined -> both debug outputs are tied to 0 and the heartbeat counter
//                is not built. The I2S outputs are identical in both builds.
//
// Parameters
//   CLK_DIV            master clocks per BCLK period (even, >= 4)
//   LED_TOGGLE_FRAMES  frames between heartbeat LED toggles (>= 1)
//
// Ports
//   clk                  in   master clock, all logic on the rising edge
//   rst                  in   synchronous reset, active low
//   new_sound_sample     in   16-bit two's complement PCM, taken once per frame
//   bit_clk_enable       out  one-clk strobe in the clk before each BCLK fall
//   bit_clock            out  I2S BCLK, 50 % duty
//   word_select          out  I2S WS, 0 = left, 1 = right
//   sound_data           out  I2S SD
//   test_LED_B           out  heartbeat LED
//   testing_bit_counter  out  current bit slot 0..31
// -----------------------------------------------------------------------------
module i2s_transmitter #(
  parameter int CLK_DIV           = 16,
  parameter int LED_TOGGLE_FRAMES = 24000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] new_sound_sample,
  output logic        bit_clk_enable,
  output logic        bit_clock,
  output logic        word_select,
  output logic        sound_data,
  output logic        test_LED_B,
  output logic [4:0]  testing_bit_counter
);

  // Elaboration-time guard on the configuration.
  if (CLK_DIV < 4 || (CLK_DIV % 2) != 0 || LED_TOGGLE_FRAMES < 1) begin : g_bad_params
    $error("i2s_transmitter: CLK_DIV must be even and >= 4, LED_TOGGLE_FRAMES >= 1");
  end

  localparam int              DIV_W    = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);

  logic [DIV_W-1:0] div_cnt_reg, div_cnt_next;
  logic             bit_clock_reg;
  logic             bit_clk_enable_reg;
  logic [4:0]       slot_reg, slot_next;
  logic [15:0]      held_reg, held_next;
  logic             word_select_reg, word_select_next;
  logic             sound_data_reg, sound_data_next;
  logic             frame_wrap;

  always_comb begin
    div_cnt_next = (div_cnt_reg == DIV_LAST) ? '0 : div_cnt_reg + DIV_W'(1);
  end

  // Slot update applied at the BCLK falling edge (the edge that ends the
  // bit_clk_enable cycle).
  always_comb begin
    slot_next        = slot_reg + 5'd1;   // 31 wraps to 0 naturally
    frame_wrap       = (slot_reg == 5'd31);
    // The sample latched on the wrap is used immediately for slot 0's MSB.
    held_next        = frame_wrap ? new_sound_sample : held_reg;
    // WS changes one slot ahead of each channel's MSB.
    word_select_next = (slot_next >= 5'd15) && (slot_next <= 5'd30);
    sound_data_next  = held_next[4'd15 - slot_next[3:0]];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      div_cnt_reg        <= '0;
      bit_clock_reg      <= 1'b0;
      bit_clk_enable_reg <= 1'b0;
      slot_reg           <= 5'd0;
      held_reg           <= 16'd0;
      word_select_reg    <= 1'b0;
      sound_data_reg     <= 1'b0;
    end else begin
      div_cnt_reg        <= div_cnt_next;
      // Both are computed from the next count so they line up with div_cnt.
      bit_clock_reg      <= (div_cnt_next >= DIV_HALF);
      bit_clk_enable_reg <= (div_cnt_next == DIV_LAST);
      if (bit_clk_enable_reg) begin
        slot_reg        <= slot_next;
        held_reg        <= held_next;
        word_select_reg <= word_select_next;
        sound_data_reg  <= sound_data_next;
      end
    end
  end

  assign bit_clock      = bit_clock_reg;
  assign bit_clk_enable = bit_clk_enable_reg;
  assign word_select    = word_select_reg;
  assign sound_data     = sound_data_reg;

`ifdef I2S_DEBUG_EN
  localparam int               FRAME_W    = $clog2(LED_TOGGLE_FRAMES + 1);
  localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(LED_TOGGLE_FRAMES - 1);

  logic [FRAME_W-1:0] frame_cnt_reg;
  logic               led_reg;

  // The counter toggles the LED on the wrap that would take it to
  // LED_TOGGLE_FRAMES, so it never holds that value.
  always_ff @(posedge clk) begin
    if (!rst) begin
      frame_cnt_reg <= '0;
      led_reg       <= 1'b0;
    end else if (bit_clk_enable_reg && frame_wrap) begin
      if (frame_cnt_reg == FRAME_LAST) begin
        frame_cnt_reg <= '0;
        led_reg       <= ~led_reg;
      end else begin
        frame_cnt_reg <= frame_cnt_reg + FRAME_W'(1);
      end
    end
  end

  assign test_LED_B          = led_reg;
  assign testing_bit_counter = slot_reg;
`else
  assign test_LED_B          = 1'b0;
  assign testing_bit_counter = 5'd0;
`endif

endmodule

// File: tb/tb_i2s_transmitter.sv
// -----------------------------------------------------------------------------
// tb_i2s_transmitter
//
// Directed bench for i2s_transmitter with CLK_DIV=16, LED_TOGGLE_FRAMES=2.
// Frames are captured MSB-first (slot 0 ends up in bit 31) so that a frame
// carrying sample S on both channels reads {S, S}.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_i2s_transmitter;

`ifdef I2S_DEBUG_EN
  localparam bit DBG = 1'b1;
`else
  localparam bit DBG = 1'b0;
`endif

  // WS over one frame, slot 0 in bit 31: slots 15..30 high.
  localparam logic [31:0] WS_FRAME = 32'h0001FFFE;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] new_sound_sample = 16'd0;
  logic        bit_clk_enable;
  logic        bit_clock;
  logic        word_select;
  logic        sound_data;
  logic        test_LED_B;
  logic [4:0]  testing_bit_counter;

  int errors = 0;
  int checks = 0;
  int tb_slot = 0;

  i2s_transmitter #(
    .CLK_DIV          (16),
    .LED_TOGGLE_FRAMES(2)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .new_sound_sample   (new_sound_sample),
    .bit_clk_enable     (bit_clk_enable),
    .bit_clock          (bit_clock),
    .word_select        (word_select),
    .sound_data         (sound_data),
    .test_LED_B         (test_LED_B),
    .testing_bit_counter(testing_bit_counter)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Advance to the next bit slot: wait for the strobe, then take the edge.
  task automatic step_slot;
    int guard;
    guard = 0;
    while (bit_clk_enable !== 1'b1 && guard < 64) begin
      tick;
      guard++;
    end
    if (guard >= 64) begin
      checks++;
      errors++;
      $display("FAIL strobe_timeout: bit_clk_enable not seen in 64 clks (slot %0d)", tb_slot);
    end
    tick;
    tb_slot = (tb_slot + 1) % 32;
  endtask

  // Capture one whole frame starting at slot 0; optionally change the input
  // sample while slot chg_slot is on the wire.
  task automatic capture_frame(input int chg_slot, input logic [15:0] chg_val,
                               output logic [31:0] sd_bits, output logic [31:0] ws_bits,
                               output int cnt_bad);
    sd_bits = '0;
    ws_bits = '0;
    cnt_bad = 0;
    while (tb_slot != 0) step_slot;
    for (int s = 0; s < 32; s++) begin
      logic [4:0] exp_cnt;
      if (s > 0) step_slot;
      if (s == chg_slot) new_sound_sample = chg_val;
      sd_bits = {sd_bits[30:0], sound_data};
      ws_bits = {ws_bits[30:0], word_select};
      exp_cnt = DBG ? 5'(s) : 5'd0;
      if (testing_bit_counter !== exp_cnt) cnt_bad++;
    end
  endtask

  task automatic test_reset;
    int first_en;
    int bclk_bad;
    rst = 1'b0;
    new_sound_sample = 16'hA5C3;
    repeat (2) tick;
    checks++;
    if ({bit_clk_enable, bit_clock, word_select, sound_data, test_LED_B, testing_bit_counter} !== 10'd0) begin
      errors++;
      $display("FAIL reset_outputs: en=%b bclk=%b ws=%b sd=%b led=%b cnt=%0d, all must be 0",
               bit_clk_enable, bit_clock, word_select, sound_data, test_LED_B, testing_bit_counter);
    end else $display("check reset_outputs ok");
    rst = 1'b1;
    // Cycle 1 after release has div_cnt=0; the strobe belongs in cycle 16.
    first_en = -1;
    bclk_bad = 0;
    if (bit_clk_enable === 1'b1) first_en = 0;
    if (bit_clock !== 1'b0) bclk_bad++;
    for (int k = 1; k <= 15; k++) begin
      tick;
      if (bit_clk_enable === 1'b1 && first_en < 0) first_en = k;
      if (bit_clock !== (k >= 8)) bclk_bad++;
    end
    checks++;
    if (first_en != 15) begin
      errors++;
      $display("FAIL first_strobe: seen after %0d clk edges, required 15 (16th clk)", first_en);
    end else $display("check first_strobe ok");
    checks++;
    if (bclk_bad != 0) begin
      errors++;
      $display("FAIL bclk_shape: %0d cycles wrong, required low 8 then high 8", bclk_bad);
    end else $display("check bclk_shape ok");
    tb_slot = 0;
  endtask

  task automatic test_slots_and_zero_frame;
    logic [31:0] sd_bits, ws_bits;
    int cnt_bad;
    capture_frame(-1, 16'h0000, sd_bits, ws_bits, cnt_bad);
    checks++;
    if (sd_bits !== 32'h0) begin
      errors++;
      $display("FAIL frame0_sd: got %h, required 00000000", sd_bits);
    end else $display("check frame0_sd ok");
    checks++;
    if (ws_bits !== WS_FRAME) begin
      errors++;
      $display("FAIL frame0_ws: got %h, required %h", ws_bits, WS_FRAME);
    end else $display("check frame0_ws ok");
    checks++;
    if (cnt_bad != 0) begin
      errors++;
      $display("FAIL slot_counter: %0d slots wrong, required 0", cnt_bad);
    end else $display("check slot_counter ok");
  endtask

  task automatic test_data;
    logic [31:0] sd_bits, ws_bits;
    int cnt_bad;
    capture_frame(-1, 16'h0000, sd_bits, ws_bits, cnt_bad);
    checks++;
    if (sd_bits !== 32'hA5C3A5C3) begin
      errors++;
      $display("FAIL frame1_sd: got %h, required a5c3a5c3", sd_bits);
    end else $display("check frame1_sd ok");
    checks++;
    if (ws_bits !== WS_FRAME) begin
      errors++;
      $display("FAIL frame1_ws: got %h, required %h", ws_bits, WS_FRAME);
    end else $display("check frame1_ws ok");
    checks++;
    if (cnt_bad != 0) begin
      errors++;
      $display("FAIL slot_wrap: %0d slots wrong in frame 1, required 0", cnt_bad);
    end else $display("check slot_wrap ok");
  endtask

  task automatic test_sample_change;
    logic [31:0] sd_bits, ws_bits;
    int cnt_bad;
    capture_frame(10, 16'h7FFF, sd_bits, ws_bits, cnt_bad);
    checks++;
    if (sd_bits !== 32'hA5C3A5C3) begin
      errors++;
      $display("FAIL frame2_unchanged: got %h, required a5c3a5c3", sd_bits);
    end else $display("check frame2_unchanged ok");
    capture_frame(-1, 16'h0000, sd_bits, ws_bits, cnt_bad);
    checks++;
    if (sd_bits !== 32'h7FFF7FFF) begin
      errors++;
      $display("FAIL frame3_new_sample: got %h, required 7fff7fff", sd_bits);
    end else $display("check frame3_new_sample ok");
  endtask

  // Sixteen samples within one bit slot, starting right after BCLK falls.
  task automatic test_bit_clock;
    int high_cnt, first_high;
    step_slot;
    high_cnt = 0;
    first_high = -1;
    for (int k = 0; k < 16; k++) begin
      if (k > 0) tick;
      if (bit_clock === 1'b1) begin
        high_cnt++;
        if (first_high < 0) first_high = k;
      end
    end
    checks++;
    if (high_cnt != 8 || first_high != 8) begin
      errors++;
      $display("FAIL bclk_period: high for %0d clks from clk %0d, required 8 from clk 8", high_cnt, first_high);
    end else $display("check bclk_period ok");
  endtask

  task automatic test_reset_mid_frame;
    int n;
    logic [31:0] sd_bits, ws_bits;
    int cnt_bad;
    while (tb_slot != 20) step_slot;
    repeat (3) tick;
    rst = 1'b0;
    tick;
    checks++;
    if ({testing_bit_counter, word_select, sound_data, bit_clock, bit_clk_enable} !== 9'd0) begin
      errors++;
      $display("FAIL mid_reset: cnt=%0d ws=%b sd=%b bclk=%b en=%b, all must be 0",
               testing_bit_counter, word_select, sound_data, bit_clock, bit_clk_enable);
    end else $display("check mid_reset ok");
    rst = 1'b1;
    n = 0;
    while (bit_clk_enable !== 1'b1 && n < 40) begin
      tick;
      n++;
    end
    checks++;
    if (n != 15) begin
      errors++;
      $display("FAIL mid_reset_divider: strobe after %0d clk edges, required 15", n);
    end else $display("check mid_reset_divider ok");
    tb_slot = 0;
    // Held sample was cleared, so this frame is silent despite input 7FFF.
    capture_frame(-1, 16'h0000, sd_bits, ws_bits, cnt_bad);
    checks++;
    if (sd_bits !== 32'h0) begin
      errors++;
      $display("FAIL post_reset_frame: got %h, required 00000000", sd_bits);
    end else $display("check post_reset_frame ok");
  endtask

  // Counter was cleared by the last reset; the capture above left us at slot 31.
  task automatic test_heartbeat;
    logic exp_on;
    exp_on = DBG;
    checks++;
    if (test_LED_B !== 1'b0) begin
      errors++;
      $display("FAIL led_start: got %b, required 0", test_LED_B);
    end else $display("check led_start ok");
    step_slot;                      // wrap 1
    checks++;
    if (test_LED_B !== 1'b0) begin
      errors++;
      $display("FAIL led_wrap1: got %b, required 0", test_LED_B);
    end else $display("check led_wrap1 ok");
    repeat (31) step_slot;          // slot 31, still before wrap 2
    checks++;
    if (test_LED_B !== 1'b0) begin
      errors++;
      $display("FAIL led_pre_wrap2: got %b, required 0", test_LED_B);
    end else $display("check led_pre_wrap2 ok");
    step_slot;                      // wrap 2
    checks++;
    if (test_LED_B !== exp_on) begin
      errors++;
      $display("FAIL led_wrap2: got %b, required %b", test_LED_B, exp_on);
    end else $display("check led_wrap2 ok");
    repeat (64) step_slot;          // wrap 4
    checks++;
    if (test_LED_B !== 1'b0) begin
      errors++;
      $display("FAIL led_wrap4: got %b, required 0", test_LED_B);
    end else $display("check led_wrap4 ok");
  endtask

  initial begin
    test_reset;
    test_slots_and_zero_frame;
    test_data;
    test_sample_change;
    test_bit_clock;
    test_reset_mid_frame;
    test_heartbeat;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
